// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
//   Sequencing controller for a direct-mapped cache array. It serves CPU load
//   hits from the array and refills a whole line from memory on a load miss.
//   During a refill, the requested (critical) word is captured as it streams
//   past. Stores are write-through with no write-allocate. A store that hits
//   updates the array in its accept cycle. Every store is then written to
//   memory.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   cpu_req/we/addr/wdata/sel CPU request, held until cpu_ready
//   cpu_ready, cpu_rdata      one-cycle completion pulse, load data
//   c_rd_index/offset/tag     cache read-port address (mirrors cpu_addr)
//   c_rd_hit, c_rd_data       cache read-port result
//   c_wr_index/offset/tag     cache write-port address
//   c_wr_data, c_wr_sel       cache write data and byte enables
//   c_wr_en, c_wr_new         write strobe, set valid/tag for the line
//   c_wr_hit                  cache write-port hit
//   mem_req/we/addr/wdata/sel memory request, held until mem_ack
//   mem_ack, mem_rdata        memory acceptance / read data
//   perf_hits, perf_misses    saturating load hit / miss counters
// -----------------------------------------------------------------------------
module cache_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int OFFSET_WIDTH = 2,
   parameter int INDEX_WIDTH  = 5,
   parameter int TAG_WIDTH    = 5,
   parameter int ADDR_WIDTH   = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [ADDR_WIDTH-1:0]     cpu_addr,
   input  logic [DATA_WIDTH-1:0]     cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cpu_sel,
   output logic                      cpu_ready,
   output logic [DATA_WIDTH-1:0]     cpu_rdata,
   output logic [INDEX_WIDTH-1:0]    c_rd_index,
   output logic [OFFSET_WIDTH-1:0]   c_rd_offset,
   output logic [TAG_WIDTH-1:0]      c_rd_tag,
   input  logic                      c_rd_hit,
   input  logic [DATA_WIDTH-1:0]     c_rd_data,
   output logic [INDEX_WIDTH-1:0]    c_wr_index,
   output logic [OFFSET_WIDTH-1:0]   c_wr_offset,
   output logic [TAG_WIDTH-1:0]      c_wr_tag,
   output logic [DATA_WIDTH-1:0]     c_wr_data,
   output logic [DATA_WIDTH/8-1:0]   c_wr_sel,
   output logic                      c_wr_en,
   output logic                      c_wr_new,
   input  logic                      c_wr_hit,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_sel,
   input  logic                      mem_ack,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic [31:0]               perf_hits,
   output logic [31:0]               perf_misses
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam logic [OFFSET_WIDTH-1:0] LINE_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REFILL,
      S_WRITE,
      S_RESP
   } state_t;

   state_t                   r_state;
   logic [TAG_WIDTH-1:0]     r_tag;
   logic [INDEX_WIDTH-1:0]   r_index;
   logic [OFFSET_WIDTH-1:0]  r_offset;
   logic [OFFSET_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0]    r_wdata;
   logic [SEL_WIDTH-1:0]     r_sel;
   logic [DATA_WIDTH-1:0]    r_rdata;
   logic [31:0]              r_hits;
   logic [31:0]              r_misses;

   logic [TAG_WIDTH-1:0]     w_tag;
   logic [INDEX_WIDTH-1:0]   w_index;
   logic [OFFSET_WIDTH-1:0]  w_offset;
   logic                     w_load;
   logic                     w_store;
   logic                     w_last;

   assign w_tag    = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
   assign w_index  = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign w_offset = cpu_addr[OFFSET_WIDTH-1:0];
   assign w_load   = cpu_req && !cpu_we;
   assign w_store  = cpu_req && cpu_we;
   assign w_last   = (r_cnt == LINE_LAST);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_tag    <= '0;
         r_index  <= '0;
         r_offset <= '0;
         r_cnt    <= '0;
         r_wdata  <= '0;
         r_sel    <= '0;
         r_rdata  <= '0;
         r_hits   <= '0;
         r_misses <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_load) begin
                  if (c_rd_hit) begin
                     r_rdata <= c_rd_data;
                     if (r_hits != '1) r_hits <= r_hits + 32'd1;
                     r_state <= S_RESP;
                  end else begin
                     r_tag    <= w_tag;
                     r_index  <= w_index;
                     r_offset <= w_offset;
                     r_cnt    <= '0;
                     if (r_misses != '1) r_misses <= r_misses + 32'd1;
                     r_state  <= S_REFILL;
                  end
               end else if (w_store) begin
                  r_tag    <= w_tag;
                  r_index  <= w_index;
                  r_offset <= w_offset;
                  r_wdata  <= cpu_wdata;
                  r_sel    <= cpu_sel;
                  r_state  <= S_WRITE;
               end
            end
            S_REFILL: begin
               if (mem_ack) begin
                  // The requested word is caught as it streams past.
                  if (r_cnt == r_offset) r_rdata <= mem_rdata;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) r_state <= S_RESP;
               end
            end
            S_WRITE: begin
               if (mem_ack) r_state <= S_RESP;
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cpu_ready   = (r_state == S_RESP);
   assign cpu_rdata   = r_rdata;
   assign perf_hits   = r_hits;
   assign perf_misses = r_misses;

   assign c_rd_index  = w_index;
   assign c_rd_offset = w_offset;
   assign c_rd_tag    = w_tag;

   assign mem_req   = (r_state == S_REFILL) || (r_state == S_WRITE);
   assign mem_we    = (r_state == S_WRITE);
   assign mem_addr  = {r_tag, r_index, (r_state == S_WRITE) ? r_offset : r_cnt};
   assign mem_wdata = r_wdata;
   assign mem_sel   = r_sel;

   // Write-port control depends on same-cycle c_wr_hit / mem_ack, so it is
   // combinational. Strobes are held off during reset so that an interrupted
   // refill never touches the array in its reset cycle.
   always_comb begin
      c_wr_index  = r_index;
      c_wr_offset = r_cnt;
      c_wr_tag    = r_tag;
      c_wr_data   = mem_rdata;
      c_wr_sel    = '1;
      c_wr_en     = 1'b0;
      c_wr_new    = 1'b0;
      case (r_state)
         S_IDLE: begin
            c_wr_index  = w_index;
            c_wr_offset = w_offset;
            c_wr_tag    = w_tag;
            c_wr_data   = cpu_wdata;
            c_wr_sel    = cpu_sel;
            c_wr_en     = rstn && w_store && c_wr_hit;
         end
         S_REFILL: begin
            c_wr_en  = rstn && mem_ack;
            // Valid/tag are set only with the final word of the line.
            c_wr_new = rstn && mem_ack && w_last;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cpu_req, cpu_we;
   logic [11:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_sel;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic [4:0]  c_rd_index, c_rd_tag, c_wr_index, c_wr_tag;
   logic [1:0]  c_rd_offset, c_wr_offset;
   logic        c_rd_hit, c_wr_hit;
   logic [31:0] c_rd_data, c_wr_data;
   logic [3:0]  c_wr_sel;
   logic        c_wr_en, c_wr_new;
   logic        mem_req, mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_sel;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] perf_hits, perf_misses;

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk(clk), .rstn(rstn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .c_rd_index(c_rd_index), .c_rd_offset(c_rd_offset), .c_rd_tag(c_rd_tag),
      .c_rd_hit(c_rd_hit), .c_rd_data(c_rd_data),
      .c_wr_index(c_wr_index), .c_wr_offset(c_wr_offset), .c_wr_tag(c_wr_tag),
      .c_wr_data(c_wr_data), .c_wr_sel(c_wr_sel), .c_wr_en(c_wr_en),
      .c_wr_new(c_wr_new), .c_wr_hit(c_wr_hit),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_sel(mem_sel),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .perf_hits(perf_hits), .perf_misses(perf_misses)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int a);
      case (a)
         12'h120: return 32'h1111A0A0;
         12'h121: return 32'h2222A1A1;
         12'h122: return 32'h3333A2A2;
         12'h123: return 32'h4444A3A3;
         default: return 32'hC0DE0000 | 32'(a);
      endcase
   endfunction

   // ---------------- cache array environment ----------------
   logic        arr_valid [32];
   logic [4:0]  arr_tag   [32];
   logic [31:0] arr_data  [32][4];
   logic        env_init = 1'b1;
   logic        pend_en, pend_new;
   logic [4:0]  pend_idx, pend_tag;
   logic [1:0]  pend_off;
   logic [31:0] pend_data;
   logic [3:0]  pend_sel;

   always_comb begin
      c_rd_hit  = arr_valid[c_rd_index] && (arr_tag[c_rd_index] == c_rd_tag);
      c_rd_data = arr_data[c_rd_index][c_rd_offset];
      c_wr_hit  = arr_valid[c_wr_index] && (arr_tag[c_wr_index] == c_wr_tag);
   end

   always @(posedge clk) begin
      if (env_init) begin
         for (int i = 0; i < 32; i++) begin
            arr_valid[i] <= 1'b0;
            arr_tag[i]   <= 5'd0;
            for (int w = 0; w < 4; w++) arr_data[i][w] <= 32'h0;
         end
      end else if (pend_en) begin
         for (int b = 0; b < 4; b++)
            if (pend_sel[b]) arr_data[pend_idx][pend_off][8*b +: 8] <= pend_data[8*b +: 8];
         if (pend_new) begin
            arr_valid[pend_idx] <= 1'b1;
            arr_tag[pend_idx]   <= pend_tag;
         end
      end
   end

   // ---------------- memory responder ----------------
   logic [31:0] ref_mem [4096];
   int mem_delay = 1;
   int wait_cnt  = 0;
   bit mem_loaded = 0;

   always @(negedge clk) begin
      if (!mem_loaded) begin
         for (int a = 0; a < 4096; a++) ref_mem[a] = init_word(a);
         mem_loaded = 1;
      end
      if (mem_req && wait_cnt >= mem_delay) begin
         mem_ack   = 1'b1;
         mem_rdata = ref_mem[mem_addr];
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_sel[b]) ref_mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
         wait_cnt = 0;
      end else begin
         mem_ack  = 1'b0;
         wait_cnt = mem_req ? wait_cnt + 1 : 0;
      end
   end

   // ---------------- spec-level model ----------------
   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
   } acc_t;

   acc_t        exp_q[$];
   logic [31:0] golden [4096];
   logic        m_valid [32];
   logic [4:0]  m_tag   [32];
   int          m_hits = 0, m_misses = 0;
   bit          txn_active = 0, txn_done = 0, txn_we = 0, txn_store_hit = 0;
   logic [11:0] txn_addr = 12'h0;
   int          txn_lat = 0, txn_cyc = 0, acks_seen = 0;
   logic [31:0] exp_rdata = 32'h0;

   // ---------------- compare process ----------------
   always begin
      acc_t e;
      bit   rd_ack;
      @(negedge clk);
      #2;
      pend_en   = c_wr_en;   pend_new = c_wr_new;
      pend_idx  = c_wr_index; pend_off = c_wr_offset; pend_tag = c_wr_tag;
      pend_data = c_wr_data; pend_sel = c_wr_sel;
      if (rstn === 1'b1) begin
         chk("c_rd_addr", 32'({c_rd_tag, c_rd_index, c_rd_offset}), 32'(cpu_addr));
         chk("no_spurious_mem_req", 32'(mem_req && exp_q.size() == 0), 32'd0);
         chk("no_spurious_ready", 32'(cpu_ready && !txn_active), 32'd0);
         rd_ack = 0;
         if (mem_req && mem_ack && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            acks_seen++;
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            if (e.we) begin
               chk("mem_wdata", mem_wdata, e.data);
               chk("mem_sel", 32'(mem_sel), 32'(e.sel));
            end else begin
               rd_ack = 1;
               chk("refill_wr_en", 32'(c_wr_en), 32'd1);
               chk("refill_wr_addr", 32'({c_wr_tag, c_wr_index, c_wr_offset}), 32'(e.addr));
               chk("refill_wr_data", c_wr_data, mem_rdata);
               chk("refill_wr_sel", 32'(c_wr_sel), 32'hF);
               chk("refill_wr_new", 32'(c_wr_new), 32'(e.addr[1:0] == 2'd3));
            end
         end
         if (!rd_ack) begin
            if (txn_active && txn_we && txn_cyc == 0) begin
               chk("store_wr_en", 32'(c_wr_en), 32'(txn_store_hit));
               chk("store_wr_new", 32'(c_wr_new), 32'd0);
               if (txn_store_hit) begin
                  chk("store_wr_addr", 32'({c_wr_tag, c_wr_index, c_wr_offset}), 32'(txn_addr));
                  chk("store_wr_data", c_wr_data, cpu_wdata);
                  chk("store_wr_sel", 32'(c_wr_sel), 32'(cpu_sel));
               end
            end else begin
               chk("c_wr_quiet", 32'({c_wr_en, c_wr_new}), 32'd0);
            end
         end
         if (cpu_ready && txn_active) begin
            chk("latency", 32'(txn_cyc), 32'(txn_lat));
            if (!txn_we) chk("cpu_rdata", cpu_rdata, exp_rdata);
            chk("perf_hits", perf_hits, 32'(m_hits));
            chk("perf_misses", perf_misses, 32'(m_misses));
            $display("txn %s addr=%h rdata=%h latency=%0d hits=%0d misses=%0d",
                     txn_we ? "store" : "load ", txn_addr, cpu_rdata, txn_cyc,
                     perf_hits, perf_misses);
            txn_active = 0;
            txn_done   = 1;
         end
         if (txn_active) txn_cyc++;
      end
   end

   // ---------------- driver ----------------
   task automatic do_txn(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [3:0] sel, input int delay, input int abort_word);
      logic [4:0] tg, ix;
      bit         hit, aborted;
      acc_t       e;
      @(negedge clk);
      tg = addr[11:7];
      ix = addr[6:2];
      hit = m_valid[ix] && (m_tag[ix] == tg);
      aborted = 0;
      mem_delay = delay;
      acks_seen = 0;
      txn_cyc = 0;
      txn_done = 0;
      txn_we = we;
      txn_addr = addr;
      if (we) begin
         e.we = 1'b1; e.addr = addr; e.data = wd; e.sel = sel;
         exp_q.push_back(e);
         for (int b = 0; b < 4; b++)
            if (sel[b]) golden[addr][8*b +: 8] = wd[8*b +: 8];
         txn_store_hit = hit;
         txn_lat = 2 + delay;
      end else begin
         exp_rdata = golden[addr];
         if (hit) begin
            m_hits++;
            txn_lat = 1;
         end else begin
            m_misses++;
            for (int k = 0; k < 4; k++) begin
               e.we = 1'b0; e.addr = {addr[11:2], 2'(k)}; e.data = 32'h0; e.sel = 4'h0;
               exp_q.push_back(e);
            end
            txn_lat = 5 + 4 * delay;
         end
      end
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_sel = sel;
      txn_active = 1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (txn_done) break;
         if (abort_word >= 0 && acks_seen == abort_word) begin
            rstn = 1'b0;
            cpu_req = 1'b0;
            txn_active = 0;
            exp_q.delete();
            m_hits = 0;
            m_misses = 0;
            aborted = 1;
            @(negedge clk);
            rstn = 1'b1;
            #3;
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
            chk("rst_cpu_rdata", cpu_rdata, 32'd0);
            chk("rst_perf_hits", perf_hits, 32'd0);
            chk("rst_perf_misses", perf_misses, 32'd0);
            $display("txn reset during refill of addr=%h", addr);
            break;
         end
      end
      if (!aborted) begin
         chk("txn_completed", 32'(txn_done), 32'd1);
         if (!txn_done) begin
            txn_active = 0;
            exp_q.delete();
         end
      end
      cpu_req = 1'b0;
      if (txn_done && !we && !hit) begin
         m_valid[ix] = 1'b1;
         m_tag[ix]   = tg;
      end
   endtask

   initial begin
      rstn = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h0; cpu_wdata = 32'h0; cpu_sel = 4'h0;
      for (int a = 0; a < 4096; a++) golden[a] = init_word(a);
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 5'd0;
      end
      repeat (3) @(negedge clk);
      env_init = 1'b0;
      rstn = 1'b1;
      #3;
      chk("init_mem_req", 32'(mem_req), 32'd0);
      chk("init_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("init_cpu_rdata", cpu_rdata, 32'd0);
      chk("init_perf_hits", perf_hits, 32'd0);
      chk("init_perf_misses", perf_misses, 32'd0);

      // cold miss, acks two cycles apart
      do_txn(1'b0, 12'h123, 32'h0, 4'h0, 1, -1);
      chk("lit_load_123", cpu_rdata, 32'h4444A3A3);
      chk("lit_misses_1", perf_misses, 32'd1);
      // hit on the refilled line
      do_txn(1'b0, 12'h121, 32'h0, 4'h0, 1, -1);
      chk("lit_load_121", cpu_rdata, 32'h2222A1A1);
      chk("lit_hits_1", perf_hits, 32'd1);
      // byte-masked store hit, then read it back
      do_txn(1'b1, 12'h122, 32'hDEADBEEF, 4'b0011, 1, -1);
      do_txn(1'b0, 12'h122, 32'h0, 4'h0, 1, -1);
      chk("lit_load_122", cpu_rdata, 32'h3333BEEF);
      // store miss (no allocate), then load miss
      do_txn(1'b1, 12'h7FF, 32'h12345678, 4'hF, 2, -1);
      do_txn(1'b0, 12'h7FF, 32'h0, 4'h0, 0, -1);
      chk("lit_load_7ff", cpu_rdata, 32'h12345678);
      // reset while the third refill word is outstanding, then retry
      do_txn(1'b0, 12'h345, 32'h0, 4'h0, 1, 2);
      do_txn(1'b0, 12'h345, 32'h0, 4'h0, 1, -1);
      chk("lit_misses_after_rst", perf_misses, 32'd1);
      chk("lit_hits_after_rst", perf_hits, 32'd0);
      // same-cycle acknowledges on every refill word
      do_txn(1'b0, 12'h0A6, 32'h0, 4'h0, 0, -1);
      do_txn(1'b0, 12'h0A4, 32'h0, 4'h0, 0, -1);
      do_txn(1'b1, 12'h0A5, 32'hCAFEF00D, 4'b1100, 0, -1);
      do_txn(1'b0, 12'h0A5, 32'h0, 4'h0, 0, -1);
      chk("lit_load_0a5", cpu_rdata, 32'hCAFE00A5);
      // conflicting tag evicts the line
      do_txn(1'b0, 12'h8A6, 32'h0, 4'h0, 1, -1);
      do_txn(1'b0, 12'h0A6, 32'h0, 4'h0, 1, -1);
      chk("lit_load_0a6", cpu_rdata, 32'hC0DE00A6);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
